deagg_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one deaggregator between NUM_SRC wide-word sources (prefetch FIFOs).

---
 rtl/deagg_pkg.sv | 18 +
 rtl/rr_pick.sv | 39 +++
 rtl/deagg_rr_scheduler.sv | 119 +++++++++++
 tb/tb_deagg_rr_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/deagg_pkg.sv
// Shared types and helpers for the deaggregator front-end (scheduler and
// deaggregator agree on element/word geometry through these defaults).
package deagg_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 9;
    localparam int DEFAULT_FETCH_WIDTH = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } sched_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request found when
// searching upward from ptr, wrapping modulo N. Purely combinational.
module rr_pick
    import deagg_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // cand[gi] is the source index visited at search offset gi.
    logic [W-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            assign sum       = {1'b0, ptr} + (W+1)'(gi);
            assign cand[gi]  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                found = 1'b1;
                idx   = cand[i];
            end
        end
    end

endmodule

// File: rtl/deagg_rr_scheduler.sv
// Round-robin scheduler sharing one deaggregator among NUM_SRC wide-word
// sources. Grants change only at word boundaries; at most BURST_LEN words
// per grant, then one idle bubble before the next arbitration.
module deagg_rr_scheduler
    import deagg_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
    parameter int BURST_LEN   = 4,
    parameter int SRC_W       = clog2_min1(NUM_SRC)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic [NUM_SRC*FETCH_WIDTH*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]                        src_empty_n,
    output logic [NUM_SRC-1:0]                        src_deq,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0]         dg_data,
    output logic                                      dg_empty_n,
    input  logic                                      dg_deq,
    output logic                                      grant_valid,
    output logic [SRC_W-1:0]                          grant_id
);

    localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;
    localparam int CNT_W  = $clog2(BURST_LEN + 1);

    sched_state_t     state_q,     state_d;
    logic [SRC_W-1:0] grant_id_q,  grant_id_d;
    logic [SRC_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_found;
    logic [SRC_W-1:0] pick_idx;
    logic             head_avail;
    logic             accept;
    logic             burst_last;
    logic [SRC_W-1:0] ptr_after_grant;
    logic [WORD_W-1:0] src_word [NUM_SRC];

    rr_pick #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_pick (
        .req   (src_empty_n),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A word is consumed only when the granted source really presents one;
    // nothing is popped in a reset cycle, since the deaggregator drops it too.
    assign grant_valid = (state_q == S_GRANT);
    assign grant_id    = grant_id_q;
    assign head_avail  = src_empty_n[grant_id_q];
    assign accept      = grant_valid & head_avail & dg_deq & ~rst;
    assign dg_empty_n  = grant_valid & head_avail & ~rst;
    assign dg_data     = src_word[grant_id_q];
    assign burst_last  = (burst_cnt_q == CNT_W'(BURST_LEN - 1));
    assign ptr_after_grant = (grant_id_q == SRC_W'(NUM_SRC - 1)) ? '0
                                                                  : grant_id_q + SRC_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_word[gi] = src_data[gi*WORD_W +: WORD_W];
            assign src_deq[gi]  = accept & (grant_id_q == SRC_W'(gi));
        end
    endgenerate

    // Next-state: arbitrate in IDLE, count words and decide release in GRANT.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable && pick_found) begin
                    state_d     = S_GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                // An empty head means the last word was already popped,
                // so releasing here never tears a word.
                if ((accept && burst_last) || !head_avail) begin
                    state_d     = S_IDLE;
                    rr_ptr_d    = ptr_after_grant;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_deagg_rr_scheduler.sv
// Bench for deagg_rr_scheduler: source FIFOs and the deaggregator are modelled
// as queues; a transaction-level reference predicts each cycle's outputs and
// each consumed word, and a separate monitor compares against the DUT.
module tb_deagg_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 9;
    localparam int FW = 4;
    localparam int BL = 4;
    localparam int SW = 2;
    localparam int WW = FW * DW;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [N*WW-1:0]   src_data;
    logic [N-1:0]      src_empty_n;
    logic [N-1:0]      src_deq;
    logic [WW-1:0]     dg_data;
    logic              dg_empty_n;
    logic              dg_deq;
    logic              grant_valid;
    logic [SW-1:0]     grant_id;

    deagg_rr_scheduler #(
        .NUM_SRC     (N),
        .DATA_WIDTH  (DW),
        .FETCH_WIDTH (FW),
        .BURST_LEN   (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .src_data    (src_data),
        .src_empty_n (src_empty_n),
        .src_deq     (src_deq),
        .dg_data     (dg_data),
        .dg_empty_n  (dg_empty_n),
        .dg_deq      (dg_deq),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          gv;
        logic [SW-1:0] gid;
        logic          den;
        logic [N-1:0]  sdeq;
        logic [WW-1:0] dat;
    } cyc_t;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [WW-1:0] data;
    } word_t;

    cyc_t          cyc_q [$];
    word_t         word_q [$];
    logic [WW-1:0] srcq [N][$];
    int            word_no [N];

    // Reference state: who owns the deaggregator, where the search starts,
    // words taken in this grant, and the last granted index.
    int m_owner, m_ptr, m_words, m_last;

    int errors;
    int checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word n of source k carries elements 100k+4n .. 100k+4n+3.
    task automatic push_word(input int k);
        logic [WW-1:0] w;
        for (int j = 0; j < FW; j++) w[j*DW +: DW] = DW'(100 * k + 4 * word_no[k] + j);
        srcq[k].push_back(w);
        word_no[k]++;
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < N; k++) srcq[k].delete();
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the reference.
    task automatic step(input logic r, input logic en, input logic dq, input logic [N-1:0] fill);
        cyc_t e;
        word_t w;
        bit   head, acc, rel, got;
        int   c;
        for (int k = 0; k < N; k++)
            if (fill[k] && srcq[k].size() < 6) push_word(k);
        rst    = r;
        enable = en;
        dg_deq = dq;
        for (int k = 0; k < N; k++) begin
            src_empty_n[k] = (srcq[k].size() > 0);
            src_data[k*WW +: WW] = (srcq[k].size() > 0) ? srcq[k][0] : 36'hBADBADBAD;
        end
        head   = (m_owner >= 0) && (srcq[m_owner].size() > 0);
        acc    = head && dq && !r;
        e.gv   = (m_owner >= 0);
        e.gid  = SW'(m_last);
        e.den  = head && !r;
        e.sdeq = acc ? (N'(1) << m_owner) : '0;
        e.dat  = head ? srcq[m_owner][0] : '0;
        cyc_q.push_back(e);
        if (acc) begin
            w.src  = SW'(m_owner);
            w.data = srcq[m_owner][0];
            word_q.push_back(w);
            void'(srcq[m_owner].pop_front());
        end
        if (r) begin
            m_owner = -1; m_ptr = 0; m_words = 0; m_last = 0;
        end else if (m_owner < 0) begin
            got = 0;
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!got && src_empty_n[c]) begin
                        got = 1; m_owner = c; m_last = c; m_words = 0;
                    end
                end
            end
        end else begin
            rel = (acc && m_words == BL - 1) || !head;
            if (acc) m_words++;
            if (rel) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_words = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    cyc_t  mon_e;
    word_t mon_w;

    // Monitor: compare every predicted cycle, and every popped word.
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            chk("grant_valid", 64'(grant_valid), 64'(mon_e.gv));
            chk("grant_id",    64'(grant_id),    64'(mon_e.gid));
            chk("dg_empty_n",  64'(dg_empty_n),  64'(mon_e.den));
            chk("src_deq",     64'(src_deq),     64'(mon_e.sdeq));
            if (mon_e.den) chk("dg_data", 64'(dg_data), 64'(mon_e.dat));
            if (src_deq != '0) begin
                if (word_q.size() == 0) begin
                    chk("word_unexpected", 64'(src_deq), 64'(0));
                end else begin
                    mon_w = word_q.pop_front();
                    chk("word_src",  64'(grant_id), 64'(mon_w.src));
                    chk("word_data", 64'(dg_data),  64'(mon_w.data));
                    $display("word src=%0d data=%09h", grant_id, dg_data);
                end
            end
        end
    end

    initial begin
        errors = 0; checks = 0;
        m_owner = -1; m_ptr = 0; m_words = 0; m_last = 0;
        for (int k = 0; k < N; k++) word_no[k] = 0;
        rst = 1'b1; enable = 1'b0; dg_deq = 1'b0;
        src_empty_n = '0; src_data = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with every source full and dg_deq asserted.
        for (int k = 0; k < N; k++) for (int n = 0; n < 4; n++) push_word(k);
        step(1'b1, 1'b1, 1'b1, '1);
        step(1'b1, 1'b1, 1'b1, '1);

        // All sources full, dg_deq every 4th cycle: rotation 0,1,2,3,0.
        for (int c = 0; c < 80; c++) step(1'b0, 1'b1, (c % 4) == 3, '1);

        // Only source 2 with two words; then sources 0 and 3 race from ptr 3.
        clear_srcs();
        step(1'b1, 1'b0, 1'b0, '0);
        push_word(2); push_word(2);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b1, '0);
        push_word(0); push_word(3);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b1, '0);

        // enable drops during source 1's burst; source 2 follows after.
        clear_srcs();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int n = 0; n < 8; n++) push_word(1);
        for (int n = 0; n < 4; n++) push_word(2);
        for (int c = 0; c < 2; c++)  step(1'b0, 1'b1, 1'b1, '0);
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 1'b1, '0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b1, '0);

        // Reset lands mid-grant of source 3 while a word is being taken.
        clear_srcs();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int n = 0; n < 6; n++) push_word(3);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1, '0);
        step(1'b1, 1'b1, 1'b1, '0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b1, '0);

        // Randomized traffic, occasional resets and enable drops.
        for (int c = 0; c < 600; c++)
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 1) == 1, N'($urandom_range(0, 15) & $urandom_range(0, 15)));

        step(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        chk("words_left", 64'(word_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
